// File: rtl/rmii_tx_sched.sv
// rmii_tx_sched: round-robin scheduler that shares one RMII TX port between NUM_REQ byte sources.
// Optional feature macro RMII_TX_PAD_EN pads short frames with 0x00 up to MIN_FRAME_B payload bytes.
module rmii_tx_sched #(
    parameter int NUM_REQ        = 2,
    parameter int IFG_CYCLES     = 48,
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_FRAME_B    = 60
) (
    input  logic                 rmii_refclk,
    input  logic                 rst_l,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] tx_data,
    input  logic [NUM_REQ-1:0]   tx_valid,
    input  logic [NUM_REQ-1:0]   tx_last,
    output logic [NUM_REQ-1:0]   tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [1:0]           rmii_txd,
    output logic                 rmii_tx_en,
    output logic                 frame_done,
    output logic                 tx_underrun
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 16;
    localparam logic [10:0] PAD_TARGET = 11'(MIN_FRAME_B);
`ifdef RMII_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_PAD  = 3'd4,
        ST_IFG  = 3'd5
    } state_t;

    state_t             state_q;
    logic [1:0]         dib_q;
    logic [7:0]         shift_q;
    logic               last_q;
    logic [10:0]        payload_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [1:0]         txd_q;
    logic               tx_en_q;
    logic               frame_done_q;
    logic               tx_underrun_q;

    logic               arb_hit_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic [IDX_W-1:0]   rr_ptr_d;
    logic [10:0]        payload_d;
    logic               fetch_s;
    logic               pad_needed_s;
    logic [7:0]         lane_byte_s;
    logic               lane_valid_s;
    logic               lane_last_s;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= NUM_REQ) ? IDX_W'(sum - NUM_REQ) : IDX_W'(sum);
    endfunction

    assign rr_ptr_d     = wrap_add(gidx_q, 1);
    assign payload_d    = (payload_q == 11'h7FF) ? payload_q : payload_q + 11'd1;
    assign fetch_s      = (dib_q == 2'd3) &&
                          ((state_q == ST_SFD) || ((state_q == ST_DATA) && !last_q));
    assign pad_needed_s = PAD_EN && (payload_q < PAD_TARGET);
    assign lane_byte_s  = tx_data[{gidx_q, 3'b000} +: 8];
    assign lane_valid_s = tx_valid[gidx_q];
    assign lane_last_s  = tx_last[gidx_q];

    assign tx_ready     = fetch_s ? grant_q : '0;
    assign grant        = grant_q;
    assign busy         = (state_q != ST_IDLE);
    assign rmii_txd     = txd_q;
    assign rmii_tx_en   = tx_en_q;
    assign frame_done   = frame_done_q;
    assign tx_underrun  = tx_underrun_q;

    // Round-robin pick: scan downward so the lowest offset from the pointer wins.
    always_comb begin
        arb_hit_s = 1'b0;
        arb_idx_s = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            arb_idx_s = req[wrap_add(rr_ptr_q, off)] ? wrap_add(rr_ptr_q, off) : arb_idx_s;
            arb_hit_s = arb_hit_s | req[wrap_add(rr_ptr_q, off)];
        end
    end

    // Frame FSM; every RMII-facing output is registered here.
    always_ff @(posedge rmii_refclk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= ST_IDLE;
            dib_q         <= 2'd0;
            shift_q       <= 8'h00;
            last_q        <= 1'b0;
            payload_q     <= 11'd0;
            cnt_q         <= '0;
            gidx_q        <= '0;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            txd_q         <= 2'b00;
            tx_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_hit_s) begin
                        state_q   <= ST_PRE;
                        gidx_q    <= arb_idx_s;
                        grant_q   <= NUM_REQ'(1'b1) << arb_idx_s;
                        tx_en_q   <= 1'b1;
                        txd_q     <= 2'b01;
                        dib_q     <= 2'd0;
                        cnt_q     <= '0;
                        payload_q <= 11'd0;
                        last_q    <= 1'b0;
                    end
                end
                ST_PRE: begin
                    dib_q <= dib_q + 2'd1;
                    txd_q <= 2'b01;
                    if (dib_q == 2'd3) begin
                        if (cnt_q == CNT_W'(PREAMBLE_BYTES - 1)) begin
                            state_q <= ST_SFD;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_SFD, ST_DATA: begin
                    if (dib_q != 2'd3) begin
                        dib_q <= dib_q + 2'd1;
                        if (state_q == ST_SFD) begin
                            txd_q <= (dib_q == 2'd2) ? 2'b11 : 2'b01;
                        end else begin
                            txd_q   <= shift_q[1:0];
                            shift_q <= {2'b00, shift_q[7:2]};
                        end
                    end else if (fetch_s) begin
                        if (lane_valid_s) begin
                            state_q   <= ST_DATA;
                            dib_q     <= 2'd0;
                            txd_q     <= lane_byte_s[1:0];
                            shift_q   <= {2'b00, lane_byte_s[7:2]};
                            last_q    <= lane_last_s;
                            payload_q <= payload_d;
                        end else begin
                            state_q       <= ST_IFG;
                            tx_en_q       <= 1'b0;
                            txd_q         <= 2'b00;
                            tx_underrun_q <= 1'b1;
                            grant_q       <= '0;
                            rr_ptr_q      <= rr_ptr_d;
                            cnt_q         <= '0;
                            dib_q         <= 2'd0;
                        end
                    end else if (pad_needed_s) begin
                        state_q   <= ST_PAD;
                        dib_q     <= 2'd0;
                        txd_q     <= 2'b00;
                        payload_q <= payload_d;
                    end else begin
                        state_q      <= ST_IFG;
                        tx_en_q      <= 1'b0;
                        txd_q        <= 2'b00;
                        frame_done_q <= 1'b1;
                        grant_q      <= '0;
                        rr_ptr_q     <= rr_ptr_d;
                        cnt_q        <= '0;
                        dib_q        <= 2'd0;
                    end
                end
`ifdef RMII_TX_PAD_EN
                ST_PAD: begin
                    txd_q <= 2'b00;
                    if (dib_q != 2'd3) begin
                        dib_q <= dib_q + 2'd1;
                    end else if (pad_needed_s) begin
                        dib_q     <= 2'd0;
                        payload_q <= payload_d;
                    end else begin
                        state_q      <= ST_IFG;
                        tx_en_q      <= 1'b0;
                        frame_done_q <= 1'b1;
                        grant_q      <= '0;
                        rr_ptr_q     <= rr_ptr_d;
                        cnt_q        <= '0;
                        dib_q        <= 2'd0;
                    end
                end
`endif
                // The IDLE arbitration cycle is the final gap cycle, so IFG itself lasts one less.
                ST_IFG: begin
                    if (cnt_q == CNT_W'(IFG_CYCLES - 2)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_en_q <= 1'b0;
                    txd_q   <= 2'b00;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_tx_sched.sv
// Directed self-checking bench for rmii_tx_sched (NUM_REQ=2, default timing parameters).
module tb_rmii_tx_sched;
`ifdef RMII_TX_PAD_EN
    localparam int T2_LEN  = 272;
    localparam int ONE_LEN = 272;
`else
    localparam int T2_LEN  = 44;
    localparam int ONE_LEN = 36;
`endif
    localparam int GAP = 48;

    logic        clk;
    logic        rst_l;
    logic [1:0]  req;
    logic [15:0] tx_data;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_last;
    logic [1:0]  tx_ready;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  rmii_txd;
    logic        rmii_tx_en;
    logic        frame_done;
    logic        tx_underrun;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] lane_mem [2][8];
    int lane_len [2] = '{0, 0};
    int lane_gap [2] = '{-1, -1};
    int lane_gen [2] = '{0, 0};

    logic [1:0] cap_q [$];
    int         en_q  [$];
    int         low_q [$];
    logic [1:0] gnt_q [$];
    int done_cnt = 0;
    int und_cnt  = 0;
    int rdy_bad  = 0;
    int acc_cnt  = 0;
    int txd_bad  = 0;

    logic [1:0] t2_pay [12] = '{2'b01, 2'b00, 2'b10, 2'b10,
                                2'b10, 2'b00, 2'b00, 2'b00,
                                2'b11, 2'b00, 2'b11, 2'b00};

    rmii_tx_sched dut (
        .rmii_refclk (clk),
        .rst_l       (rst_l),
        .req         (req),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy),
        .rmii_txd    (rmii_txd),
        .rmii_tx_en  (rmii_tx_en),
        .frame_done  (frame_done),
        .tx_underrun (tx_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_lane(input int ln, input int len, input int gap,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        lane_mem[ln][0] = b0;
        lane_mem[ln][1] = b1;
        lane_mem[ln][2] = b2;
        lane_len[ln]    = len;
        lane_gap[ln]    = gap;
        lane_gen[ln]    = lane_gen[ln] + 1;
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] exp, input int budget);
        int n;
        n = 0;
        while (grant == 2'b00 && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, 32'(grant), 32'(exp));
    endtask

    task automatic wait_not_busy(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < budget);
        check_val(tag, 32'(busy), 32'd0);
    endtask

    function automatic int en_at(input int i);
        return (i < en_q.size()) ? en_q[i] : -1;
    endfunction

    function automatic int low_at(input int i);
        return (i < low_q.size()) ? low_q[i] : -1;
    endfunction

    function automatic int gnt_at(input int i);
        return (i < gnt_q.size()) ? int'(gnt_q[i]) : 99;
    endfunction

    // Byte sources: a lane advances when it was ready&valid across the edge, and rewinds after tx_last.
    initial begin : src
        int         pos  [2];
        int         seen [2];
        logic [1:0] acc;
        pos      = '{0, 0};
        seen     = '{0, 0};
        tx_data  = 16'h0000;
        tx_valid = 2'b00;
        tx_last  = 2'b00;
        forever begin
            @(negedge clk);
            acc = tx_ready & tx_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (seen[i] != lane_gen[i]) begin
                    seen[i] = lane_gen[i];
                    pos[i]  = 0;
                end else if (acc[i]) begin
                    pos[i] = (pos[i] == lane_len[i] - 1) ? 0 : pos[i] + 1;
                end
                tx_data[8*i +: 8] = lane_mem[i][pos[i]];
                tx_valid[i]       = (lane_len[i] > 0) && (pos[i] != lane_gap[i]);
                tx_last[i]        = (pos[i] == lane_len[i] - 1);
            end
        end
    end

    // Line monitor: run lengths, captured dibits, pulse counts and grant history.
    initial begin : mon
        logic       prev_en;
        logic [1:0] prev_grant;
        int         en_run;
        int         low_run;
        prev_en    = 1'b0;
        prev_grant = 2'b00;
        en_run     = 0;
        low_run    = 0;
        forever begin
            @(negedge clk);
            if (rmii_tx_en) begin
                if (!prev_en) begin
                    low_q.push_back(low_run);
                    en_run = 0;
                end
                en_run++;
                cap_q.push_back(rmii_txd);
            end else begin
                if (prev_en) begin
                    en_q.push_back(en_run);
                    low_run = 0;
                end
                low_run++;
                if (rmii_txd != 2'b00) txd_bad++;
            end
            prev_en = rmii_tx_en;
            if (frame_done) done_cnt++;
            if (tx_underrun) und_cnt++;
            if ((tx_ready & ~grant) != 2'b00) rdy_bad++;
            if ((tx_ready & tx_valid) != 2'b00) acc_cnt++;
            if (grant != 2'b00 && prev_grant == 2'b00) gnt_q.push_back(grant);
            prev_grant = grant;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cs, es, ls, gs, d0, u0, a0, mism, n;
        logic [1:0] expd;

        rst_l = 1'b0;
        req   = 2'b00;
        repeat (3) tick();
        check_val("rst_tx_en", 32'(rmii_tx_en), 32'd0);
        check_val("rst_txd", 32'(rmii_txd), 32'd0);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_tx_ready", 32'(tx_ready), 32'd0);
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        check_val("rst_underrun", 32'(tx_underrun), 32'd0);
        rst_l = 1'b1;
        repeat (2) tick();

        // Single 3-byte frame from lane 0; req dropped mid-frame.
        load_lane(0, 3, -1, 8'hA1, 8'h02, 8'h33);
        repeat (3) tick();
        cs = cap_q.size(); es = en_q.size(); d0 = done_cnt; u0 = und_cnt; a0 = acc_cnt;
        req = 2'b01;
        wait_grant("t2_grant", 2'b01, 10);
        req = 2'b00;
        wait_not_busy("t2_end", 600);
        check_val("t2_en_len", 32'(en_at(es)), 32'(T2_LEN));
        mism = 0;
        for (int k = 0; k < T2_LEN; k++) begin
            if (k < 31)       expd = 2'b01;
            else if (k == 31) expd = 2'b11;
            else if (k < 44)  expd = t2_pay[k-32];
            else              expd = 2'b00;
            if (cs + k >= cap_q.size()) mism++;
            else if (cap_q[cs+k] !== expd) mism++;
        end
        check_val("t2_dibits", 32'(mism), 32'd0);
        check_val("t2_done", 32'(done_cnt - d0), 32'd1);
        check_val("t2_underrun", 32'(und_cnt - u0), 32'd0);
        check_val("t2_accepts", 32'(acc_cnt - a0), 32'd3);

        // Asynchronous reset in the middle of the preamble.
        d0 = done_cnt;
        req = 2'b01;
        wait_grant("t1_grant", 2'b01, 10);
        repeat (5) tick();
        req = 2'b00;
        #3;
        rst_l = 1'b0;
        #1;
        check_val("t1_tx_en", 32'(rmii_tx_en), 32'd0);
        check_val("t1_grant_clr", 32'(grant), 32'd0);
        check_val("t1_busy", 32'(busy), 32'd0);
        check_val("t1_tx_ready", 32'(tx_ready), 32'd0);
        repeat (2) tick();
        rst_l = 1'b1;
        repeat (3) tick();
        check_val("t1_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("t1_idle", 32'(busy), 32'd0);

        // Both lanes requesting one-byte frames: alternation and gap length.
        load_lane(0, 1, -1, 8'h5A, 8'h00, 8'h00);
        load_lane(1, 1, -1, 8'hC3, 8'h00, 8'h00);
        repeat (3) tick();
        gs = gnt_q.size(); ls = low_q.size(); es = en_q.size(); d0 = done_cnt;
        req = 2'b11;
        n = 0;
        while (gnt_q.size() < gs + 3 && n < 3 * (ONE_LEN + GAP) + 100) begin
            tick();
            n++;
        end
        req = 2'b00;
        wait_not_busy("t3_end", 600);
        check_val("t3_frames", 32'(gnt_q.size() - gs), 32'd3);
        check_val("t3_grant0", 32'(gnt_at(gs)), 32'd1);
        check_val("t3_grant1", 32'(gnt_at(gs + 1)), 32'd2);
        check_val("t3_grant2", 32'(gnt_at(gs + 2)), 32'd1);
        check_val("t3_gap1", 32'(low_at(ls + 1)), 32'(GAP));
        check_val("t3_gap2", 32'(low_at(ls + 2)), 32'(GAP));
        check_val("t3_en_len", 32'(en_at(es)), 32'(ONE_LEN));
        check_val("t3_done", 32'(done_cnt - d0), 32'd3);

        // Underrun on lane 1's second byte, then pointer must have moved on to lane 0.
        load_lane(1, 2, 1, 8'h11, 8'h22, 8'h00);
        repeat (3) tick();
        gs = gnt_q.size(); ls = low_q.size(); es = en_q.size(); d0 = done_cnt; u0 = und_cnt;
        req = 2'b10;
        wait_grant("t4_grant", 2'b10, 10);
        req = 2'b00;
        n = 0;
        while (und_cnt == u0 && n < 200) begin
            tick();
            n++;
        end
        check_val("t4_underrun", 32'(und_cnt - u0), 32'd1);
        check_val("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("t4_en_len", 32'(en_at(es)), 32'd36);
        req = 2'b11;
        n = 0;
        while (gnt_q.size() < gs + 2 && n < 200) begin
            tick();
            n++;
        end
        req = 2'b00;
        check_val("t4_rr_next", 32'(gnt_at(gs + 1)), 32'd1);
        check_val("t4_gap", 32'(low_at(ls + 1)), 32'(GAP));
        wait_not_busy("t4_end", 600);
        check_val("t4_und_width", 32'(und_cnt - u0), 32'd1);

        check_val("ready_other_lane", 32'(rdy_bad), 32'd0);
        check_val("txd_idle_zero", 32'(txd_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
